// File: rtl/ts_split_1to7.sv
// ts_split_1to7: receives one framed burst of up to MAX_PKT concatenated
// TS packets behind a 2-byte big-endian length header, validates it into a
// frame buffer, then releases packets one at a time on an ack handshake.
module ts_split_1to7 #(
  parameter int          PKT_LEN   = 188,
  parameter int          MAX_PKT   = 7,
  parameter int          ADDR_W    = 11,
  parameter logic [7:0]  SYNC_BYTE = 8'h47
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] iv_data,
  input  logic       i_data_en,
  input  logic       i_ack,
  output logic       o_ready,
  output logic [7:0] ov_ts,
  output logic       o_ts_en,
  output logic       o_err,
  output logic       o_drop
);

  // state    | meaning
  // W_IDLE   | waiting for a frame start (rising i_data_en)
  // W_LEN0   | registered byte is the length high byte
  // W_LEN1   | registered byte is the length low byte; length checked
  // W_DATA   | payload bytes written to the frame buffer
  // W_DROP   | discarding the rest of the burst (busy buffer or error)
  // R_IDLE   | o_ready raised while validated packets remain
  // R_RD     | streaming one packet's addresses out of the buffer

  localparam int FRAME_MAX = PKT_LEN * MAX_PKT;
  localparam int CNT_W     = $clog2(MAX_PKT + 1);
  localparam int OFF_W     = $clog2(PKT_LEN);

  typedef enum logic [2:0] {W_IDLE, W_LEN0, W_LEN1, W_DATA, W_DROP} w_state_t;
  typedef enum logic       {R_IDLE, R_RD} r_state_t;

  w_state_t          w_state;
  r_state_t          r_state;

  logic              en_prev;
  logic              e1;
  logic [7:0]        d1;

  logic [7:0]        len_hi;
  logic [15:0]       len;
  logic [15:0]       len_full;
  logic [ADDR_W-1:0] byte_cnt;
  logic [OFF_W-1:0]  byte_in_pkt;
  logic [CNT_W-1:0]  pkt_cnt;
  logic              err_flag;

  logic [CNT_W-1:0]  pkt_avail;
  logic [CNT_W-1:0]  rd_idx;
  logic [ADDR_W-1:0] base;
  logic [OFF_W-1:0]  rd_off;
  logic [ADDR_W-1:0] rd_addr;
  logic              ram_vld;
  logic [7:0]        ram_q;

  logic [7:0]        mem [0:(1 << ADDR_W) - 1];

  logic              frame_start;
  logic              buf_busy;
  logic              frame_ok;
  logic              wr_en;
  logic              rd_last;
  logic              rd_free;
  logic              ack_go;

  // Decode of handshake, framing and buffer-ownership conditions
  always_comb begin
    len_full    = {len_hi, d1};
    frame_start = i_data_en && !en_prev;
    rd_last     = (r_state == R_RD) && (rd_off == OFF_W'(PKT_LEN - 1));
    rd_free     = rd_last && ((rd_idx + 1'b1) == pkt_avail);
    // A buffer released this very cycle is already free for a new frame
    buf_busy    = (pkt_avail != '0) && !rd_free;
    frame_ok    = (w_state == W_DATA) && !e1 && (16'(byte_cnt) == len) &&
                  (byte_in_pkt == '0) && !err_flag;
    wr_en       = (w_state == W_DATA) && e1 && (16'(byte_cnt) < len);
    ack_go      = (r_state == R_IDLE) && o_ready && i_ack;
    rd_addr     = base + ADDR_W'(rd_off);
  end

  // Input registers; en_prev resets high so a burst live at reset release
  // is not seen as a frame start
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      en_prev <= 1'b1;
      e1      <= 1'b0;
      d1      <= '0;
    end else begin
      en_prev <= i_data_en;
      e1      <= i_data_en;
      d1      <= iv_data;
    end
  end

  // Write FSM: parses the header, fills the buffer and validates the frame
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      w_state     <= W_IDLE;
      len_hi      <= '0;
      len         <= '0;
      byte_cnt    <= '0;
      byte_in_pkt <= '0;
      pkt_cnt     <= '0;
      err_flag    <= 1'b0;
      o_err       <= 1'b0;
      o_drop      <= 1'b0;
    end else begin
      o_err  <= 1'b0;
      o_drop <= 1'b0;
      case (w_state)
        W_IDLE: begin
          if (frame_start) begin
            byte_cnt    <= '0;
            byte_in_pkt <= '0;
            pkt_cnt     <= '0;
            err_flag    <= 1'b0;
            if (buf_busy) begin
              w_state <= W_DROP;
              o_drop  <= 1'b1;
            end else begin
              w_state <= W_LEN0;
            end
          end
        end
        W_LEN0: begin
          len_hi  <= d1;
          w_state <= W_LEN1;
        end
        W_LEN1: begin
          if (!e1) begin
            o_err   <= 1'b1;
            w_state <= W_IDLE;
          end else if (len_full == 16'd0 || len_full > 16'(FRAME_MAX)) begin
            err_flag <= 1'b1;
            w_state  <= W_DROP;
          end else begin
            len     <= len_full;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (!e1) begin
            o_err   <= !frame_ok;
            w_state <= W_IDLE;
          end else if (16'(byte_cnt) == len) begin
            err_flag <= 1'b1;
            w_state  <= W_DROP;
          end else begin
            if (byte_in_pkt == '0 && d1 != SYNC_BYTE)
              err_flag <= 1'b1;
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_in_pkt == OFF_W'(PKT_LEN - 1)) begin
              byte_in_pkt <= '0;
              pkt_cnt     <= pkt_cnt + 1'b1;
            end else begin
              byte_in_pkt <= byte_in_pkt + 1'b1;
            end
          end
        end
        W_DROP: begin
          if (!e1) begin
            o_err   <= err_flag;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Frame buffer: synchronous write, synchronous read with 1-cycle latency
  always_ff @(posedge i_clk) begin
    if (wr_en)
      mem[byte_cnt] <= d1;
    ram_q <= mem[rd_addr];
  end

  // Read FSM: owns the pending-packet bookkeeping and the ready handshake
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= R_IDLE;
      pkt_avail <= '0;
      rd_idx    <= '0;
      base      <= '0;
      rd_off    <= '0;
      o_ready   <= 1'b0;
    end else begin
      if (frame_ok)
        pkt_avail <= pkt_cnt;
      case (r_state)
        R_IDLE: begin
          if (ack_go) begin
            r_state <= R_RD;
            rd_off  <= '0;
            o_ready <= 1'b0;
          end else begin
            o_ready <= (rd_idx < pkt_avail);
          end
        end
        R_RD: begin
          o_ready <= 1'b0;
          rd_off  <= rd_off + 1'b1;
          if (rd_last) begin
            r_state <= R_IDLE;
            if (rd_free) begin
              pkt_avail <= '0;
              rd_idx    <= '0;
              base      <= '0;
            end else begin
              rd_idx <= rd_idx + 1'b1;
              base   <= base + ADDR_W'(PKT_LEN);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Output register stage; data forced to zero outside a burst
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ram_vld <= 1'b0;
      o_ts_en <= 1'b0;
      ov_ts   <= '0;
    end else begin
      ram_vld <= (r_state == R_RD);
      o_ts_en <= ram_vld;
      ov_ts   <= ram_vld ? ram_q : 8'h00;
    end
  end

endmodule

// File: tb/tb_ts_split_1to7.sv
// Directed bench for ts_split_1to7: valid frames, short and malformed
// frames, busy-buffer drop and reset during a packet read.
module tb_ts_split_1to7;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [7:0] iv_data;
  logic       i_data_en;
  logic       i_ack;
  logic       o_ready;
  logic [7:0] ov_ts;
  logic       o_ts_en;
  logic       o_err;
  logic       o_drop;

  int vectors     = 0;
  int miscompares = 0;
  int err_cnt     = 0;
  int drop_cnt    = 0;

  ts_split_1to7 dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .iv_data  (iv_data),
    .i_data_en(i_data_en),
    .i_ack    (i_ack),
    .o_ready  (o_ready),
    .ov_ts    (ov_ts),
    .o_ts_en  (o_ts_en),
    .o_err    (o_err),
    .o_drop   (o_drop)
  );

  always #5 i_clk = ~i_clk;

  // Pulse counters sampled mid-cycle
  always @(negedge i_clk) begin
    if (o_err)  err_cnt++;
    if (o_drop) drop_cnt++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int p, input int b, input int seed);
    int v;
    if (b == 0)      v = 8'h47;
    else if (b == 1) v = p;
    else             v = p * 31 + b * 3 + seed;
    return v[7:0];
  endfunction

  task automatic send_frame(input int len_field, input int nbytes,
                            input int seed, input int bad_pkt);
    int p, b;
    @(posedge i_clk); #1;
    i_data_en = 1'b1;
    iv_data   = len_field[15:8];
    @(posedge i_clk); #1;
    iv_data   = len_field[7:0];
    for (int i = 0; i < nbytes; i++) begin
      @(posedge i_clk); #1;
      p = i / 188;
      b = i % 188;
      iv_data = (p == bad_pkt && b == 0) ? 8'h00 : exp_byte(p, b, seed);
    end
    @(posedge i_clk); #1;
    i_data_en = 1'b0;
    iv_data   = 8'h00;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    @(negedge i_clk);
    while (!o_ready && n < 40) begin
      @(negedge i_clk);
      n++;
    end
    chk(tag, o_ready, 1);
  endtask

  task automatic read_pkt(input int p, input int seed);
    wait_ready($sformatf("ready_p%0d", p));
    if (!o_ready) return;
    i_ack = 1'b1;
    @(posedge i_clk); #1;
    i_ack = 1'b0;
    @(negedge i_clk);
    chk("ready_drop", o_ready, 0);
    chk("en_lat1", o_ts_en, 0);
    @(negedge i_clk);
    chk("en_lat2", o_ts_en, 0);
    chk("ts_zero_lat", ov_ts, 0);
    for (int b = 0; b < 188; b++) begin
      @(negedge i_clk);
      chk($sformatf("en_p%0d_b%0d", p, b), o_ts_en, 1);
      chk($sformatf("data_p%0d_b%0d", p, b), ov_ts, exp_byte(p, b, seed));
    end
    @(negedge i_clk);
    chk("en_after", o_ts_en, 0);
    chk("ts_zero_after", ov_ts, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0, d0, cnt;
    i_reset = 1'b1; i_data_en = 1'b0; iv_data = 8'h00; i_ack = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ready", o_ready, 0);
    chk("rst_ts_en", o_ts_en, 0);
    chk("rst_ts",    ov_ts, 0);
    chk("rst_err",   o_err, 0);
    chk("rst_drop",  o_drop, 0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    repeat (3) @(posedge i_clk);

    // Seven-packet frame, all delivered
    e0 = err_cnt; d0 = drop_cnt;
    send_frame(16'h0524, 1316, 1, -1);
    for (int p = 0; p < 7; p++) read_pkt(p, 1);
    repeat (5) @(negedge i_clk);
    chk("ready_empty_7", o_ready, 0);

    // Two-packet frame accepted after the buffer emptied; extra ack ignored
    send_frame(16'h0178, 376, 4, -1);
    for (int p = 0; p < 2; p++) read_pkt(p, 4);
    i_ack = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge i_clk);
      if (o_ts_en) cnt++;
    end
    i_ack = 1'b0;
    chk("extra_ack_en", cnt, 0);
    chk("extra_ack_ready", o_ready, 0);
    chk("t12_err", err_cnt - e0, 0);
    chk("t12_drop", drop_cnt - d0, 0);

    // Length not a multiple of the packet size
    e0 = err_cnt;
    send_frame(16'h00C8, 200, 7, -1);
    @(posedge i_clk);
    @(posedge i_clk);
    @(negedge i_clk);
    chk("len200_err_pulse", o_err, 1);
    @(negedge i_clk);
    chk("len200_err_end", o_err, 0);
    repeat (10) @(negedge i_clk);
    chk("len200_ready", o_ready, 0);
    chk("len200_err_cnt", err_cnt - e0, 1);

    // Packet 3 with a bad sync byte
    e0 = err_cnt;
    send_frame(16'h0524, 1316, 2, 3);
    @(posedge i_clk);
    @(posedge i_clk);
    @(negedge i_clk);
    chk("sync_err_pulse", o_err, 1);
    repeat (10) @(negedge i_clk);
    chk("sync_ready", o_ready, 0);
    chk("sync_err_cnt", err_cnt - e0, 1);

    // Second frame while seven packets are pending is dropped
    send_frame(16'h0524, 1316, 5, -1);
    wait_ready("pending_ready");
    e0 = err_cnt; d0 = drop_cnt;
    send_frame(16'h0524, 1316, 9, -1);
    repeat (4) @(negedge i_clk);
    chk("busy_drop_cnt", drop_cnt - d0, 1);
    chk("busy_err_cnt", err_cnt - e0, 0);
    for (int p = 0; p < 7; p++) read_pkt(p, 5);
    repeat (5) @(negedge i_clk);
    chk("ready_empty_drop", o_ready, 0);

    // Reset during a packet read with a burst live across release
    send_frame(16'h0524, 1316, 2, -1);
    wait_ready("pre_reset_ready");
    i_ack = 1'b1;
    @(posedge i_clk); #1;
    i_ack = 1'b0;
    repeat (60) @(negedge i_clk);
    chk("mid_read_en", o_ts_en, 1);
    @(posedge i_clk); #1;
    i_reset = 1'b1; i_data_en = 1'b1; iv_data = 8'h00;
    repeat (3) @(posedge i_clk);
    #1 i_reset = 1'b0;
    iv_data = 8'hBC;
    e0 = err_cnt; d0 = drop_cnt;
    @(negedge i_clk);
    chk("post_rst_en", o_ts_en, 0);
    chk("post_rst_ready", o_ready, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge i_clk); #1;
      iv_data = (i == 0) ? 8'h47 : 8'(i);
      @(negedge i_clk);
      if (o_ts_en || o_ready) cnt++;
    end
    @(posedge i_clk); #1;
    i_data_en = 1'b0; iv_data = 8'h00;
    repeat (10) begin
      @(negedge i_clk);
      if (o_ts_en || o_ready) cnt++;
    end
    chk("ignored_burst_activity", cnt, 0);
    chk("ignored_burst_err", err_cnt - e0, 0);
    chk("ignored_burst_drop", drop_cnt - d0, 0);
    send_frame(16'h0178, 376, 3, -1);
    for (int p = 0; p < 2; p++) read_pkt(p, 3);
    repeat (5) @(negedge i_clk);
    chk("final_ready", o_ready, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ts_split_1to7.md
Name: ts_split_1to7

Overview:
- Inverse of the 7-in-1 TS multiplexer: receives one framed burst carrying up to 7 concatenated 188-byte MPEG-TS packets behind a 2-byte length header.
- Buffers the burst, validates it, then releases packets one at a time to a downstream consumer.
- Per-packet handshake: o_ready / i_ack.
- Sits between the aggregated-frame receive path and per-packet TS processing.

Parameters:
- PKT_LEN, 188, bytes per TS packet.
- MAX_PKT, 7, maximum packets per frame.
- ADDR_W, 11, frame buffer address width; buffer depth is 2^ADDR_W bytes and must be at least PKT_LEN*MAX_PKT.
- SYNC_BYTE, 8'h47, required first byte of each packet.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset.
- iv_data  in  8  frame byte.
- i_data_en  in  1  frame byte valid; one frame is one contiguous high burst.
- i_ack  in  1  consumer request for the next packet.
- o_ready  out  1  at least one validated packet is pending.
- ov_ts  out  8  packet byte out.
- o_ts_en  out  1  packet byte valid.
- o_err  out  1  one-cycle pulse: frame rejected.
- o_drop  out  1  one-cycle pulse: frame discarded because the buffer is occupied.

Behaviour:
- Reset: i_reset is synchronous, active-high; clock is i_clk. All outputs reset to 0, both FSMs go to idle, the buffer is marked empty.
- If i_data_en is high when reset releases, that burst is ignored until i_data_en goes low.
- Frame format, byte by byte:
  - byte0 = length high byte.
  - byte1 = length low byte; L is big-endian.
  - Then L payload bytes.
  - Frame start = i_data_en rising after being low. Frame end = first cycle with i_data_en low.
- Write FSM:
  - W_IDLE: on frame start, go to W_LEN0. If the buffer is not empty (packets pending or a read in progress), go to W_DROP instead and pulse o_drop.
  - W_LEN0 -> W_LEN1: capture the high byte.
  - W_LEN1: capture the low byte. If L == 0 or L > PKT_LEN*MAX_PKT, go to W_DROP and flag an error. Otherwise go to W_DATA.
  - W_DATA: write each byte to RAM at addresses 0..L-1. Counters: byte_cnt (11 bit), byte_in_pkt (0..PKT_LEN-1, wraps), pkt_cnt (increments on each wrap).
    - At byte_in_pkt == 0, a byte not equal to SYNC_BYTE flags an error.
    - More than L payload bytes flags an error and goes to W_DROP.
    - At frame end, the frame is valid only if: byte_cnt == L, byte_in_pkt == 0, and no error is flagged. If valid, load pkt_avail = pkt_cnt and return to W_IDLE. Otherwise pulse o_err and return to W_IDLE.
  - W_DROP: stay until frame end. If the drop was caused by an error, pulse o_err. Then return to W_IDLE.
  - Frames of 0 or 1 bytes end as errors, with an o_err pulse.
- o_ready rises on the clock edge after pkt_avail is loaded.
- o_ready is high in R_IDLE while rd_idx < pkt_avail.
- Read FSM:
  - R_IDLE: when i_ack == 1 and o_ready == 1, go to R_RD. o_ready drops on the next edge. i_ack while o_ready is low is ignored.
  - R_RD: issue addresses base+0 .. base+PKT_LEN-1, one per cycle. RAM read is synchronous with 1-cycle latency, and the output is registered.
    - Latency: o_ts_en is high for exactly PKT_LEN consecutive cycles, starting the second edge after the edge that sampled i_ack.
    - ov_ts is 0 whenever o_ts_en is low.
  - After the last address: base += PKT_LEN and rd_idx += 1.
    - If rd_idx == pkt_avail, clear pkt_avail, rd_idx and base; the buffer is freed. Otherwise return to R_IDLE.
    - i_ack held during R_RD has no effect. The next packet needs i_ack while o_ready is high.
- Write and read never overlap: a new frame is accepted only once the buffer is free.
- Buffer freed and frame start in the same cycle: the frame is accepted.

Test Plan:
- L=0x0524 (1316), 7 packets; each packet starts with 0x47 and has byte1 = packet index 0..6. Ack each time o_ready is high -> 7 bursts of 188 bytes, byte-exact, o_ts_en starting 2 cycles after each ack. o_ready is low after the 7th ack, and a new frame is then accepted.
- L=0x0178 (376), 2 packets -> exactly 2 packets delivered; a third ack is ignored (no o_ts_en).
- L=0x00C8 (200, not a multiple of 188) followed by 200 bytes -> o_err pulse one cycle after frame end; o_ready stays 0.
- Valid frame where packet 3 starts with 0x00 -> o_err pulse; no packets delivered.
- Valid frame pending (0 of 7 read), then a second frame arrives -> o_drop pulse at its start; the original 7 packets are delivered unchanged.
- Reset asserted mid-packet during R_RD, with i_data_en high across reset release -> o_ts_en 0, o_ready 0, and the in-flight burst is ignored; the next full frame is processed normally.
